// File: rtl/piho_pkg.sv
// piho_pkg: Q16.16 format constants, observer FSM states and the saturating accumulate add.
package piho_pkg;
  localparam int FRAC = 16;
  localparam int ACC_W = 64;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/piho_sq_acc.sv
// piho_sq_acc: register, signed square and saturating Q32.32 accumulate, three stages, with a clear that wins.
module piho_sq_acc import piho_pkg::*; #(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             busy,
  output logic [ACC_W-1:0] acc
);
  logic v1_q, v1_d, v2_q, v2_d;
  logic signed [DW-1:0] d_q, d_d;
  logic signed [2*DW-1:0] p_q, p_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  always_comb begin
    v1_d = in_valid;
    d_d = in_data;
    v2_d = v1_q;
    p_d = d_q * d_q;
    acc_d = clr ? '0 : v2_q ? sat_add(acc_q, ACC_W'($unsigned(p_q))) : acc_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d_q <= '0;
      p_q <= '0;
      acc_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d_q <= d_d;
      p_q <= p_d;
      acc_q <= acc_d;
    end
  assign busy = v1_q | v2_q;
  assign acc = acc_q;
endmodule

// File: rtl/piho_observer.sv
// piho_observer: post-sweep lattice readout with fixed-point x^2 accumulation and an optional raw sample stream.
// Define PIHO_OBS_STREAM_EN to build the 2-entry sample FIFO and the smp_* stream.
module piho_observer import piho_pkg::*; #(
  parameter int SITES = 128,
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sweep_done,
  input  logic [31:0]   warmupskip,
  input  logic [15:0]   stride,
  input  logic          clr_stats,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          smp_valid,
  input  logic          smp_ready,
  output logic [DW-1:0] smp_data,
  output logic          smp_last,
  output logic          busy,
  output logic          meas_done,
  output logic [31:0]   sweeps,
  output logic [31:0]   nmeas,
  output logic [63:0]   x2sum,
  output logic [15:0]   overrun
);
  state_t state_q, state_d;
  logic [AW:0] k_q, k_d;
  logic rv_q, rv_d, md_q, md_d;
  logic [31:0] sweeps_q, sweeps_d, nmeas_q, nmeas_d;
  logic [15:0] overrun_q, overrun_d, ph_q, ph_d, ph_inc, stride_eff;
  logic can_rd, fifo_empty, sq_busy, last_rd, post, start, drop, fin;
  piho_sq_acc #(.DW(DW)) u_sq (
    .clk(clk), .rst(rst), .clr(clr_stats), .in_valid(rv_q), .in_data(rd_data), .busy(sq_busy), .acc(x2sum)
  );
  // ph tracks (sweeps - warmupskip) mod stride without a divider
  always_comb begin
    rd_en = state_q == SCAN && can_rd;
    last_rd = rd_en && k_q == (AW+1)'(SITES - 1);
    rv_d = rd_en;
    stride_eff = stride == '0 ? 16'd1 : stride;
    ph_inc = ph_q + 16'd1;
    sweeps_d = sweeps_q + 32'(sweep_done);
    post = sweeps_d > warmupskip;
    ph_d = !sweep_done ? ph_q : (!post || ph_inc >= stride_eff) ? '0 : ph_inc;
    start = sweep_done && state_q == IDLE && post && ph_d == '0;
    drop = sweep_done && state_q != IDLE;
    fin = state_q == DRAIN && !rv_q && !sq_busy && fifo_empty;
    state_d = start ? SCAN : last_rd ? DRAIN : fin ? IDLE : state_q;
    k_d = start ? '0 : rd_en ? k_q + 1'b1 : k_q;
    nmeas_d = clr_stats ? '0 : fin ? nmeas_q + 32'd1 : nmeas_q;
    overrun_d = clr_stats ? '0 : (drop && overrun_q != 16'hFFFF) ? overrun_q + 16'd1 : overrun_q;
    md_d = fin;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      rv_q <= 1'b0;
      md_q <= 1'b0;
      sweeps_q <= '0;
      nmeas_q <= '0;
      overrun_q <= '0;
      ph_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      rv_q <= rv_d;
      md_q <= md_d;
      sweeps_q <= sweeps_d;
      nmeas_q <= nmeas_d;
      overrun_q <= overrun_d;
      ph_q <= ph_d;
    end
  assign rd_bank = k_q[0];
  assign rd_addr = k_q[AW:1];
  assign busy = state_q != IDLE;
  assign meas_done = md_q;
  assign sweeps = sweeps_q;
  assign nmeas = nmeas_q;
  assign overrun = overrun_q;
`ifdef PIHO_OBS_STREAM_EN
  logic [DW:0] mem_q [2], mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d, rl_q, rl_d, pop;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] occ;
  assign smp_valid = cnt_q != 2'd0;
  assign {smp_last, smp_data} = mem_q[rp_q];
  assign pop = smp_valid && smp_ready;
  // occupancy as it stands after this cycle's pop, so a ready-high stream sustains one read per cycle
  assign occ = 3'(cnt_q) + 3'(rv_q) - 3'(pop);
  assign can_rd = occ < 3'd2;
  assign fifo_empty = !smp_valid;
  always_comb begin
    mem_d = mem_q;
    mem_d[wp_q] = rv_q ? {rl_q, rd_data} : mem_q[wp_q];
    wp_d = wp_q ^ rv_q;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + 2'(rv_q) - 2'(pop);
    rl_d = last_rd;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
      rl_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rl_q <= rl_d;
    end
`else
  logic unused_ready;
  assign unused_ready = smp_ready;
  assign smp_valid = 1'b0;
  assign smp_last = 1'b0;
  assign smp_data = '0;
  assign can_rd = 1'b1;
  assign fifo_empty = 1'b1;
`endif
endmodule

// File: tb/tb_piho_observer.sv
// tb_piho_observer: randomized scoreboard bench; the model predicts scans and sums of squares from the sweep rules.
module tb_piho_observer;
  import piho_pkg::*;
  localparam int SITES = 128, DW = 32, AW = 6;
`ifdef PIHO_OBS_STREAM_EN
  localparam int TOG_LAT = 0;
`else
  localparam int TOG_LAT = SITES + 5;
`endif
  typedef struct { logic [63:0] x2; logic [31:0] nm; longint st; int lat; } exp_t;
  logic clk = 0, rst = 1, sweep_done = 0, clr_stats = 0, smp_ready = 1;
  logic [31:0] warmupskip = 0;
  logic [15:0] stride = 1;
  logic rd_en, rd_bank, smp_valid, smp_last, busy, meas_done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = 0, smp_data;
  logic [31:0] sweeps, nmeas;
  logic [63:0] x2sum;
  logic [15:0] overrun;
  piho_observer #(.SITES(SITES), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sweep_done(sweep_done), .warmupskip(warmupskip), .stride(stride),
    .clr_stats(clr_stats), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data), .smp_last(smp_last),
    .busy(busy), .meas_done(meas_done), .sweeps(sweeps), .nmeas(nmeas), .x2sum(x2sum), .overrun(overrun)
  );
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [DW-1:0] site [SITES];
  always @(posedge clk) if (rd_en) rd_data <= site[{rd_addr, rd_bank}];
  int checks = 0, errors = 0, rk = 0, sv_bad = 0;
  logic [31:0] sweeps_m = 0, nmeas_m = 0;
  logic [63:0] x2_m = 0;
  logic [15:0] overrun_m = 0;
  longint busy_until = -1;
  exp_t exp_q[$];
  logic [DW:0] smp_q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sweep(input int clr_off = 0, input int lat = SITES + 5);
    exp_t e;
    logic [79:0] tot;
    longint v;
    int s_eff;
    s_eff = stride == 0 ? 1 : int'(stride);
    sweep_done = 1;
    sweeps_m++;
    if (cyc <= busy_until) overrun_m = overrun_m == 16'hFFFF ? overrun_m : overrun_m + 16'd1;
    else if (sweeps_m > warmupskip && (sweeps_m - warmupskip) % s_eff == 0) begin
      tot = clr_off != 0 ? 80'd0 : 80'(x2_m);
      for (int k = 0; k < SITES; k++)
        if (clr_off == 0 || k + 4 > clr_off) begin
          v = longint'($signed(site[k]));
          tot += 80'(v * v);
        end
      x2_m = tot > {16'h0, {64{1'b1}}} ? '1 : tot[63:0];
      nmeas_m = (clr_off != 0 ? 32'd0 : nmeas_m) + 32'd1;
      e = '{x2_m, nmeas_m, cyc, lat};
      exp_q.push_back(e);
      busy_until = cyc + SITES + 4;
`ifdef PIHO_OBS_STREAM_EN
      for (int k = 0; k < SITES; k++) smp_q.push_back({k == SITES - 1, site[k]});
`endif
    end
    tick();
    sweep_done = 0;
  endtask
  task automatic clr(input bit mid);
    clr_stats = 1;
    overrun_m = 0;
    if (!mid) begin
      x2_m = 0;
      nmeas_m = 0;
    end
    tick();
    clr_stats = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
    sweeps_m = 0;
    nmeas_m = 0;
    x2_m = 0;
    overrun_m = 0;
    busy_until = -1;
    exp_q.delete();
    smp_q.delete();
    rk = 0;
  endtask
  task automatic wait_idle(input bit tog);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) begin
      smp_ready = tog ? (i % 3 == 0) : 1'b1;
      tick();
    end
    smp_ready = 1;
    chk("scan completes", 64'(exp_q.size()), 64'd0);
    chk("busy low after scan", 64'(busy), 64'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " meas_done"}, 64'(meas_done), 64'd0);
    chk({tag, " sweeps"}, 64'(sweeps), 64'd0);
    chk({tag, " nmeas"}, 64'(nmeas), 64'd0);
    chk({tag, " x2sum"}, x2sum, 64'd0);
    chk({tag, " overrun"}, 64'(overrun), 64'd0);
    chk({tag, " rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, " smp_valid"}, 64'(smp_valid), 64'd0);
  endtask
  task automatic fill_rand();
    for (int k = 0; k < SITES; k++) site[k] = 32'($urandom_range(32'h1F_FFFF)) - 32'h10_0000;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && meas_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL meas_done: pulse at cycle %0d, none required", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("x2sum at meas_done", x2sum, e.x2);
        chk("nmeas at meas_done", 64'(nmeas), 64'(e.nm));
        if (e.lat != 0) chk("scan latency", 64'(cyc - e.st), 64'(e.lat));
      end
    end
    if (!rst && rd_en) begin
      chk("read order", 64'({rd_addr, rd_bank}), 64'(rk));
      rk = (rk + 1) % SITES;
    end
  end
`ifdef PIHO_OBS_STREAM_EN
  always @(negedge clk) begin
    logic [DW:0] s;
    if (!rst && smp_valid && smp_ready) begin
      if (smp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream: transfer %h at cycle %0d, none required", {smp_last, smp_data}, cyc);
      end else begin
        s = smp_q.pop_front();
        chk("smp_data", 64'(smp_data), 64'(s[DW-1:0]));
        chk("smp_last", 64'(smp_last), 64'(s[DW]));
      end
    end
  end
`else
  always @(negedge clk) if (!rst && (smp_valid || smp_last || smp_data != 0)) sv_bad++;
`endif
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    rst = 0;
    chk_zero("reset");
    for (int k = 0; k < SITES; k++) site[k] = 32'(1 << FRAC);
    sweep();
    wait_idle(0);
    chk("x2 ones", x2sum, 64'h0000_0080_0000_0000);
    chk("nmeas ones", 64'(nmeas), 64'd1);
    clr(0);
    chk("x2 cleared", x2sum, 64'd0);
    chk("nmeas cleared", 64'(nmeas), 64'd0);
    for (int k = 0; k < SITES; k++) site[k] = k[0] ? 32'h0000_8000 : 32'hFFFF_8000;
    sweep();
    wait_idle(0);
    chk("x2 halves", x2sum, 64'h0000_0020_0000_0000);
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      sweep();
      wait_idle(0);
      chk("x2 random", x2sum, x2_m);
    end
    fill_rand();
    sweep(40);
    tick(39);
    clr(1);
    wait_idle(0);
    chk("x2 clear mid-scan", x2sum, x2_m);
    chk("nmeas clear mid-scan", 64'(nmeas), 64'd1);
    do_reset();
    warmupskip = 3;
    stride = 2;
    for (int i = 0; i < 10; i++) begin
      sweep();
      tick(199);
    end
    wait_idle(0);
    chk("warmup sweeps", 64'(sweeps), 64'd10);
    chk("warmup nmeas", 64'(nmeas), 64'd3);
    do_reset();
    warmupskip = 1;
    stride = 0;
    for (int i = 0; i < 3; i++) begin
      sweep();
      tick(149);
    end
    wait_idle(0);
    chk("stride0 nmeas", 64'(nmeas), 64'd2);
    do_reset();
    warmupskip = 0;
    stride = 1;
    fill_rand();
    sweep();
    tick(9);
    sweep();
    wait_idle(0);
    chk("overrun count", 64'(overrun), 64'd1);
    chk("overrun sweeps", 64'(sweeps), 64'(sweeps_m));
    chk("overrun nmeas", 64'(nmeas), 64'd1);
    chk("overrun x2", x2sum, x2_m);
    fill_rand();
    sweep(0, TOG_LAT);
    wait_idle(1);
    chk("x2 backpressure", x2sum, x2_m);
    for (int k = 0; k < SITES; k++) site[k] = 32'h7FFF_FFFF;
    sweep();
    wait_idle(0);
    chk("x2 saturated", x2sum, 64'hFFFF_FFFF_FFFF_FFFF);
    sweep();
    wait_idle(0);
    chk("x2 stays saturated", x2sum, 64'hFFFF_FFFF_FFFF_FFFF);
    fill_rand();
    sweep();
    tick(50);
    do_reset();
    chk_zero("abort");
    tick(200);
    chk_zero("after abort");
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    chk("stream drained", 64'(smp_q.size()), 64'd0);
    chk("stream tied off", 64'(sv_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
